// File: rtl/lms_fir_gen_if.sv
// Sample/coefficient bus for lms_fir_gen.
// The master drives the sample stream and host coefficient controls.
// The slave (the filter) returns the output/error stream and coefficient readback.
interface lms_fir_gen_if #(
    parameter int XW   = 12,
    parameter int DW   = 14,
    parameter int CW   = 16,
    parameter int TAPS = 16,
    parameter int FRAC = 10,
    parameter int MUW  = 5
);
    localparam int IW   = $clog2(TAPS);
    localparam int ACCW = XW + CW + IW;
    localparam int EW   = ACCW - FRAC + 1;

    logic                   in_valid;
    logic signed [XW-1:0]   x_in;
    logic signed [DW-1:0]   d_in;
    logic        [MUW-1:0]  mu_shift;
    logic                   adapt_en;
    logic                   coef_clear;
    logic                   coef_wr;
    logic        [IW-1:0]   coef_sel;
    logic signed [CW-1:0]   coef_wdata;
    logic                   out_valid;
    logic signed [ACCW-1:0] y_out;
    logic signed [EW-1:0]   e_out;
    logic signed [CW-1:0]   coef_q;

    modport master (
        output in_valid, x_in, d_in, mu_shift, adapt_en,
               coef_clear, coef_wr, coef_sel, coef_wdata,
        input  out_valid, y_out, e_out, coef_q
    );

    modport slave (
        input  in_valid, x_in, d_in, mu_shift, adapt_en,
               coef_clear, coef_wr, coef_sel, coef_wdata,
        output out_valid, y_out, e_out, coef_q
    );
endinterface

// File: rtl/lms_fir_gen.sv
// Parametrised LMS adaptive FIR filter.
// One sample per cycle: a sample accepted on edge n produces y/e on edge n+1,
// and the same edge applies the LMS update computed from that sample's error.
// Optional feature macro: LMS_COEF_SAT_EN -- when defined, coefficient updates
// saturate to the CW range; otherwise they wrap at CW bits.
module lms_fir_gen #(
    parameter int XW        = 12,
    parameter int DW        = 14,
    parameter int CW        = 16,
    parameter int TAPS      = 16,
    parameter int FRAC      = 10,
    parameter int UPD_SHIFT = 12,
    parameter int MUW       = 5
) (
    input  logic clk,
    input  logic reset,
    lms_fir_gen_if.slave bus
);
    localparam int IW   = $clog2(TAPS);
    localparam int ACCW = XW + CW + IW;
    localparam int EW   = ACCW - FRAC + 1;
    localparam int PW   = XW + CW;   // exact tap product width
    localparam int DPW  = EW + XW;   // exact error*sample product width

    // Registered state
    logic signed [XW-1:0]   x_q [TAPS];
    logic signed [CW-1:0]   w_q [TAPS];
    logic signed [DW-1:0]   d_q;
    logic                   pend_q;
    logic                   out_valid_q;
    logic signed [ACCW-1:0] y_q;
    logic signed [EW-1:0]   e_q;
    logic signed [CW-1:0]   rd_q;

    // Combinational datapath
    logic signed [PW-1:0]   prod [TAPS];
    logic signed [CW-1:0]   w_adapt_d [TAPS];
    logic signed [ACCW-1:0] acc;
    logic signed [EW-1:0]   e_w;
    logic signed [EW-1:0]   emu;
    logic        [MUW-1:0]  mu_sh;

    assign mu_sh = bus.mu_shift;

    genvar gi;
    generate
        for (gi = 0; gi < TAPS; gi++) begin : g_tap
            logic signed [DPW-1:0] upd_prod;

            // Full-precision tap product; the sum below cannot overflow ACCW.
            assign prod[gi] = PW'(x_q[gi]) * PW'(w_q[gi]);

            assign upd_prod = DPW'(emu) * DPW'(x_q[gi]);

`ifdef LMS_COEF_SAT_EN
            localparam logic signed [CW-1:0] CMAX = {1'b0, {(CW-1){1'b1}}};
            localparam logic signed [CW-1:0] CMIN = {1'b1, {(CW-1){1'b0}}};
            logic signed [DPW-1:0] upd_sh;
            logic signed [CW-1:0]  delta_sat;
            logic signed [CW:0]    sum_w;

            assign upd_sh = upd_prod >>> UPD_SHIFT;
            assign sum_w  = (CW+1)'(w_q[gi]) + (CW+1)'(delta_sat);

            // Clamp delta, then clamp the one-bit-wider sum, so the coefficient never wraps.
            always_comb begin
                if (upd_sh > DPW'(CMAX)) begin
                    delta_sat = CMAX;
                end else if (upd_sh < DPW'(CMIN)) begin
                    delta_sat = CMIN;
                end else begin
                    delta_sat = CW'(upd_sh);
                end
                if (sum_w > (CW+1)'(CMAX)) begin
                    w_adapt_d[gi] = CMAX;
                end else if (sum_w < (CW+1)'(CMIN)) begin
                    w_adapt_d[gi] = CMIN;
                end else begin
                    w_adapt_d[gi] = CW'(sum_w);
                end
            end
`else
            // Legacy behaviour: delta truncated to CW bits and added with wrap.
            assign w_adapt_d[gi] = w_q[gi] + CW'(upd_prod >>> UPD_SHIFT);
`endif
        end
    endgenerate

    // Dot product of the delay line with the current coefficients.
    always_comb begin
        acc = '0;
        for (int k = 0; k < TAPS; k++) begin
            acc = acc + ACCW'(prod[k]);
        end
    end

    // Error at d scale and step-size scaled error (both floor shifts).
    assign e_w = EW'(d_q) - EW'(acc >>> FRAC);
    assign emu = e_w >>> mu_sh;

    // Accept path: shift the delay line, capture d and mark a sample pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
            end
            d_q    <= '0;
            pend_q <= 1'b0;
        end else begin
            pend_q <= bus.in_valid;
            if (bus.in_valid) begin
                x_q[0] <= bus.x_in;
                for (int k = 1; k < TAPS; k++) begin
                    x_q[k] <= x_q[k-1];
                end
                d_q <= bus.d_in;
            end
        end
    end

    // Output path: register y/e for the pending sample; values hold between samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            e_q         <= '0;
        end else begin
            out_valid_q <= pend_q;
            if (pend_q) begin
                y_q <= acc;
                e_q <= e_w;
            end
        end
    end

    // Coefficient update with priority clear > host write > LMS adapt > hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) begin
                w_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                if (bus.coef_clear) begin
                    w_q[k] <= '0;
                end else if (bus.coef_wr && (bus.coef_sel == IW'(k))) begin
                    w_q[k] <= bus.coef_wdata;
                end else if (pend_q && bus.adapt_en) begin
                    w_q[k] <= w_adapt_d[k];
                end
            end
        end
    end

    // Host readback of the pre-edge coefficient; out-of-range taps read as zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q <= '0;
        end else if (32'(bus.coef_sel) < TAPS) begin
            rd_q <= w_q[bus.coef_sel];
        end else begin
            rd_q <= '0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.y_out     = y_q;
    assign bus.e_out     = e_q;
    assign bus.coef_q    = rd_q;

endmodule

// File: tb/tb_lms_fir_gen.sv
// Directed + randomized bench for lms_fir_gen against an integer LMS reference model.
module tb_lms_fir_gen;
    localparam int XW = 12, DW = 14, CW = 16, TAPS = 16, FRAC = 10, UPD_SHIFT = 12, MUW = 5;
    localparam int IW = $clog2(TAPS);

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    lms_fir_gen_if #(.XW(XW), .DW(DW), .CW(CW), .TAPS(TAPS), .FRAC(FRAC), .MUW(MUW)) bus ();

    lms_fir_gen #(.XW(XW), .DW(DW), .CW(CW), .TAPS(TAPS), .FRAC(FRAC),
                  .UPD_SHIFT(UPD_SHIFT), .MUW(MUW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_ov  = 0;

    // Reference model state (plain integers)
    longint m_x [TAPS];
    longint m_c [TAPS];
    longint m_d, m_y, m_e, m_rd;
    bit     m_pend, m_ov;

    function automatic longint wrapw(longint v, int w);
        longint m, r;
        m = longint'(1) << w;
        r = v & (m - 1);
        if (r >= (m >>> 1)) r = r - m;
        return r;
    endfunction

    function automatic longint clampw(longint v, int w);
        longint hi, lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) begin
            m_x[k] = 0;
            m_c[k] = 0;
        end
        m_d = 0; m_y = 0; m_e = 0; m_rd = 0; m_pend = 0; m_ov = 0;
    endtask

    // One clock edge of the LMS filter, using pre-edge state throughout.
    task automatic model_edge();
        longint acc, e, emu, dl;
        int sel;
        acc = 0;
        for (int k = 0; k < TAPS; k++) acc += m_x[k] * m_c[k];
        e   = m_d - (acc >>> FRAC);
        emu = e >>> int'(bus.mu_shift);
        sel = int'(bus.coef_sel);
        m_rd = (sel < TAPS) ? m_c[sel] : 0;
        m_ov = m_pend;
        if (m_pend) begin
            m_y = acc;
            m_e = e;
        end
        for (int k = 0; k < TAPS; k++) begin
            if (bus.coef_clear) begin
                m_c[k] = 0;
            end else if (bus.coef_wr && k == sel) begin
                m_c[k] = longint'(bus.coef_wdata);
            end else if (m_pend && bus.adapt_en) begin
                dl = (emu * m_x[k]) >>> UPD_SHIFT;
`ifdef LMS_COEF_SAT_EN
                m_c[k] = clampw(m_c[k] + clampw(dl, CW), CW);
`else
                m_c[k] = wrapw(m_c[k] + dl, CW);
`endif
            end
        end
        if (bus.in_valid) begin
            for (int k = TAPS - 1; k > 0; k--) m_x[k] = m_x[k-1];
            m_x[0] = longint'(bus.x_in);
            m_d    = longint'(bus.d_in);
            m_pend = 1'b1;
        end else begin
            m_pend = 1'b0;
        end
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, bus.out_valid, longint'(m_ov));
        check({tag, ".y_out"},     bus.y_out,     m_y);
        check({tag, ".e_out"},     bus.e_out,     m_e);
        check({tag, ".coef_q"},    bus.coef_q,    m_rd);
    endtask

    // Advance one clock, step the model, then compare every output.
    task automatic cycle(input string tag);
        @(posedge clk);
        if (reset) model_edge();
        #1;
        if (bus.out_valid === 1'b1) n_ov++;
        check_outputs(tag);
        $display("cyc t=%0t %s ov=%0b y=%0d e=%0d cq=%0d", $time, tag,
                 bus.out_valid, bus.y_out, bus.e_out, bus.coef_q);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_async");
        #1;
        reset = 1'b1;
    endtask

    task automatic readall(input bit expect_zero);
        bus.in_valid = 1'b0; bus.coef_wr = 1'b0; bus.coef_clear = 1'b0;
        for (int k = 0; k < TAPS; k++) begin
            bus.coef_sel = IW'(k);
            cycle("readback");
            if (expect_zero) check("readback_zero", bus.coef_q, 0);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.x_in = '0; bus.d_in = '0; bus.mu_shift = '0;
        bus.adapt_en = 1'b0; bus.coef_clear = 1'b0; bus.coef_wr = 1'b0;
        bus.coef_sel = '0; bus.coef_wdata = '0;
        model_reset();
        #12;
        check_outputs("reset_state");
        reset = 1'b1;
        @(posedge clk); #1;

        // Freeze + host write
        bus.coef_wr = 1'b1; bus.coef_sel = '0; bus.coef_wdata = 16'sd1024;
        cycle("frz_wr");
        bus.coef_wr = 1'b0;
        bus.in_valid = 1'b1; bus.x_in = 12'sd100; bus.d_in = '0;
        cycle("frz_accept");
        bus.in_valid = 1'b0;
        cycle("frz_out");
        check("frz_valid", bus.out_valid, 1);
        check("frz_y", bus.y_out, 102400);
        check("frz_e", bus.e_out, -100);
        cycle("frz_rd");
        check("frz_c0", bus.coef_q, 1024);

        // Single-sample adaptation from zero coefficients
        pulse_reset();
        bus.adapt_en = 1'b1; bus.mu_shift = '0;
        bus.in_valid = 1'b1; bus.x_in = 12'sd2047; bus.d_in = 14'sd4096;
        cycle("adp_accept");
        bus.in_valid = 1'b0;
        cycle("adp_out");
        check("adp_y", bus.y_out, 0);
        check("adp_e", bus.e_out, 4096);
        bus.adapt_en = 1'b0;
        bus.coef_sel = '0;
        cycle("adp_rd0");
        check("adp_c0", bus.coef_q, 2047);
        bus.coef_sel = IW'(1);
        cycle("adp_rd1");
        check("adp_c1", bus.coef_q, 0);
        readall(1'b0);

        // Overflow of the coefficient update
        pulse_reset();
        bus.coef_wr = 1'b1; bus.coef_wdata = 16'sd32767;
        bus.coef_sel = IW'(0); cycle("sat_wr0");
        bus.coef_sel = IW'(1); cycle("sat_wr1");
        bus.coef_wr = 1'b0; bus.adapt_en = 1'b0; bus.mu_shift = '0;
        bus.in_valid = 1'b1; bus.x_in = 12'sd1000; bus.d_in = '0;
        cycle("sat_s1");
        bus.x_in = -12'sd2048;
        cycle("sat_s2");
        bus.in_valid = 1'b0; bus.adapt_en = 1'b1;
        cycle("sat_out");
        check("sat_e", bus.e_out, 33535);
        bus.adapt_en = 1'b0;
        bus.coef_sel = IW'(1);
        cycle("sat_rd1");
`ifdef LMS_COEF_SAT_EN
        check("sat_c1", bus.coef_q, 32767);
`else
        check("sat_c1", bus.coef_q, -24582);
`endif
        bus.coef_sel = IW'(0);
        cycle("sat_rd0");
        check("sat_c0", bus.coef_q, 15999);

        // Back-to-back random stream with adaptation
        bus.adapt_en = 1'b1;
        bus.mu_shift = MUW'($urandom_range(4, 9));
        n_ov = 0;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'b1;
            bus.x_in = XW'($urandom);
            bus.d_in = DW'($urandom);
            bus.coef_sel = IW'($urandom_range(0, TAPS - 1));
            cycle("b2b");
        end
        bus.in_valid = 1'b0;
        cycle("b2b_tail");
        cycle("b2b_idle");
        check("b2b_count", n_ov, 20);
        readall(1'b0);

        // Clear and write on the same edge as an adapting output
        bus.in_valid = 1'b1; bus.x_in = XW'($urandom); bus.d_in = DW'($urandom);
        cycle("pri_accept");
        bus.in_valid = 1'b0;
        bus.coef_clear = 1'b1; bus.coef_wr = 1'b1;
        bus.coef_sel = IW'(3); bus.coef_wdata = 16'sd500;
        cycle("pri_out");
        check("pri_valid", bus.out_valid, 1);
        bus.adapt_en = 1'b0;
        readall(1'b1);

        // Reset asserted with a sample in flight
        bus.coef_wr = 1'b1; bus.coef_sel = IW'(2); bus.coef_wdata = 16'sd700;
        cycle("mid_wr");
        bus.coef_wr = 1'b0;
        bus.in_valid = 1'b1; bus.x_in = 12'sd321; bus.d_in = 14'sd55;
        cycle("mid_accept");
        check("mid_cq_nonzero", bus.coef_q, 700);
        bus.in_valid = 1'b0;
        pulse_reset();
        check("mid_ov", bus.out_valid, 0);
        check("mid_cq", bus.coef_q, 0);
        cycle("mid_after");
        check("mid_no_out", bus.out_valid, 0);
        readall(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lms_fir_gen.md
# lms_fir_gen

Parametrised LMS adaptive FIR: generalises the fixed 16-tap, 12-bit adaptive filter to arbitrary tap count and data/coefficient widths. Adds a valid-qualified sample stream, adapt/freeze control, synchronous coefficient clear, host coefficient write/readback, and optional coefficient saturation. Sits between the sample front-end (x, reference d) and downstream error/output consumers in the detector datapath.

## Interface
- XW, 12, signed input sample width
- DW, 14, signed desired-signal width
- CW, 16, signed coefficient width
- TAPS, 16, filter length (≥2)
- FRAC, 10, right-shift from accumulator scale to d scale
- UPD_SHIFT, 12, right-shift of emu·x product to coefficient scale
- MUW, 5, width of mu_shift
- Derived: ACCW = XW+CW+clog2(TAPS); EW = ACCW−FRAC+1 (must be ≥ DW+1); IW = clog2(TAPS)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  x_in/d_in valid this cycle
- x_in  in  XW  signed input sample
- d_in  in  DW  signed desired sample
- mu_shift  in  MUW  step size as arithmetic right-shift of error
- adapt_en  in  1  1 = update coefficients, 0 = freeze
- coef_clear  in  1  synchronous zero of all coefficients
- coef_wr  in  1  write coef_wdata to tap coef_sel
- coef_sel  in  IW  tap index for write/readback
- coef_wdata  in  CW  signed write data
- out_valid  out  1  y_out/e_out valid
- y_out  out  ACCW  signed filter output, accumulator scale
- e_out  out  EW  signed error
- coef_q  out  CW  registered coef[coef_sel]

## Operation
- Reset: delay line, coefficients, pending flag, d register, out_valid, y_out, e_out, coef_q all 0.
- Accept (edge with in_valid=1): x line shifts (x[0]←x_in, x[k]←x[k−1]), d_reg←d_in, pend←1; else pend←0.
- Compute (combinational on registered state): acc = Σ x[k]·coef[k] at ACCW; e = sign-extended d_reg − (acc >>> FRAC) at EW; emu = e >>> mu_shift; delta[k] = (emu·x[k]) >>> UPD_SHIFT, all arithmetic shifts (floor).
- Output (edge with pend=1): y_out←acc, e_out←e, out_valid←1; out_valid←0 otherwise; y_out/e_out hold.
- Coefficient update, per tap, priority order on each edge:
  1. coef_clear=1 → all taps 0.
  2. coef_wr=1 and k==coef_sel → coef[k]←coef_wdata.
  3. pend=1 and adapt_en=1 → coef[k]←coef[k]+delta[k] (see Configuration).
  4. hold.
- Update uses pre-edge x line and e from the same sample as the emitted output; line shift and update happen on the same edge with nonblocking semantics.
- coef_q ← coef[coef_sel] (pre-edge value) every cycle.
- delta wider than CW: truncated to low CW bits before add (wrap) unless saturation enabled.

## Timing
- Throughput: one sample per cycle; back-to-back in_valid supported.
- Latency: in_valid at edge n → out_valid, y_out, e_out at edge n+1; coefficients reflecting that sample at edge n+1, used by sample accepted at edge n+1 onward.
- adapt_en, mu_shift sampled at the output edge (n+1), not the accept edge.
- coef_q: 1-cycle read latency; write at edge m visible on coef_q at edge m+1 if coef_sel held.
- Reset mid-stream: asynchronous; all state zero immediately; no output emitted for in-flight sample.
- coef_clear/coef_wr concurrent with pend: output still emitted using pre-edge coefficients.

## Configuration
- LMS_COEF_SAT_EN defined: coef[k]+delta[k] computed at CW+1 bits and clamped to [−2^(CW−1), 2^(CW−1)−1]; delta clamped to CW range before add.
- Undefined: two's-complement wrap at CW bits (legacy behaviour).

## Test plan
- Reset: assert reset mid-stream with nonzero coefficients → out_valid, y_out, e_out, coef_q = 0 immediately; all coef read back 0.
- Freeze/write: adapt_en=0, write coef[0]=1024, one in_valid x=100, d=0 → next edge out_valid=1, y_out=102400, e_out=−100; coef[0] still 1024.
- Adapt: coefs 0, adapt_en=1, mu_shift=0, single sample x=2047, d=4096 → y_out=0, e_out=4096; coef[0] reads 2047, others 0.
- Saturation: write coef[0]=coef[1]=32767, adapt_en=0 for sample x=1000, then adapt_en=1 for sample x=−2048, d=0, mu_shift=0 → e_out=33535; coef[1]=32767 with LMS_COEF_SAT_EN, −24582 without.
- Back-to-back: 20 consecutive in_valid samples with random x/d → exactly 20 out_valid pulses, each one edge after its accept; y_out/e_out match golden LMS model bit-exactly.
- Priority: coef_clear and coef_wr (coef_sel=3, 500) on same edge as adapting pend → all coef 0 after edge; emitted output uses pre-edge coefficients.
